im2col_stream: RTL and testbench

Streaming, parametrised successor to the combinational im2col stage. It accepts an image one multi-channel pixel per handshake, stores the frame, then emits one im2col column per output position (KERNEL_SIZE×KERNEL_SIZE×CHANNELS elements) over a valid/ready interface. It honours STRIDE and zero PADDING, and sits between the pixel source and the convolution MAC array.

---
 rtl/im2col_pkg.sv | 29 ++
 rtl/im2col_window_mux.sv | 51 +++++
 rtl/im2col_stream.sv | 146 ++++++++++++++
 tb/tb_im2col_stream.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/im2col_pkg.sv
// ---------------------------------------------------------------------------
// im2col_pkg
// Shared definitions for the streaming im2col block:
//   - positions()    : number of window positions along one axis
//   - count_width()  : counter width for a range of n values (at least 1 bit)
//   - params_legal() : parameter sanity check used at elaboration
//   - state_t        : LOAD / EMIT controller states
// ---------------------------------------------------------------------------
package im2col_pkg;

    typedef enum logic {
        LOAD = 1'b0,
        EMIT = 1'b1
    } state_t;

    function automatic int positions(input int dim, input int k, input int s, input int p);
        return (dim - k + 2 * p) / s + 1;
    endfunction

    function automatic int count_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic bit params_legal(input int width, input int height, input int k,
                                        input int s, input int p);
        return (k <= width + 2 * p) && (k <= height + 2 * p) && (s >= 1);
    endfunction

endpackage

// File: rtl/im2col_window_mux.sv
// ---------------------------------------------------------------------------
// im2col_window_mux
// Purely combinational window extractor. For window position (py, px) it
// gathers the KERNEL_SIZE x KERNEL_SIZE pixels of the stored frame into one
// im2col column, substituting zero for taps that fall in the padding border.
// Ports:
//   frame      in   whole image, pixel (y, x) at slot y*IMAGE_WIDTH + x
//   py, px     in   window position counters
//   out_column out  element e=(ky*K+kx)*CHANNELS+c at [e*DATA_WIDTH +: DATA_WIDTH]
// ---------------------------------------------------------------------------
module im2col_window_mux
    import im2col_pkg::*;
#(
    parameter int IMAGE_WIDTH  = 20,
    parameter int IMAGE_HEIGHT = 20,
    parameter int KERNEL_SIZE  = 3,
    parameter int STRIDE       = 1,
    parameter int PADDING      = 0,
    parameter int DATA_WIDTH   = 8,
    parameter int CHANNELS     = 1
) (
    input  logic [IMAGE_HEIGHT*IMAGE_WIDTH*CHANNELS*DATA_WIDTH-1:0] frame,
    input  logic [count_width(positions(IMAGE_HEIGHT, KERNEL_SIZE, STRIDE, PADDING))-1:0] py,
    input  logic [count_width(positions(IMAGE_WIDTH, KERNEL_SIZE, STRIDE, PADDING))-1:0]  px,
    output logic [KERNEL_SIZE*KERNEL_SIZE*CHANNELS*DATA_WIDTH-1:0] out_column
);

    localparam int PIXEL_W = CHANNELS * DATA_WIDTH;

    int y;
    int x;

    // Channels of a pixel are already packed in element order, so each tap
    // copies a whole pixel; taps outside the image keep the zero default.
    always_comb begin
        out_column = '0;
        y          = 0;
        x          = 0;
        for (int ky = 0; ky < KERNEL_SIZE; ky++) begin
            for (int kx = 0; kx < KERNEL_SIZE; kx++) begin
                y = int'(py) * STRIDE + ky - PADDING;
                x = int'(px) * STRIDE + kx - PADDING;
                if (y >= 0 && y < IMAGE_HEIGHT && x >= 0 && x < IMAGE_WIDTH) begin
                    out_column[(ky*KERNEL_SIZE+kx)*PIXEL_W +: PIXEL_W] =
                        frame[(y*IMAGE_WIDTH+x)*PIXEL_W +: PIXEL_W];
                end
            end
        end
    end

endmodule

// File: rtl/im2col_stream.sv
// ---------------------------------------------------------------------------
// im2col_stream
// Streaming im2col stage. Accepts a frame one multi-channel pixel per
// handshake (raster order), then emits one im2col column per window position
// with STRIDE and zero PADDING applied.
// Ports:
//   clk, rst    single rising-edge clock, synchronous active-high reset
//   in_valid    pixel present          in_ready   block accepts a pixel
//   in_pixel    channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//   out_valid   column present         out_ready  consumer accepts column
//   out_column  K*K*CHANNELS elements  out_last   final column of the frame
// ---------------------------------------------------------------------------
module im2col_stream
    import im2col_pkg::*;
#(
    parameter int IMAGE_WIDTH  = 20,
    parameter int IMAGE_HEIGHT = 20,
    parameter int KERNEL_SIZE  = 3,
    parameter int STRIDE       = 1,
    parameter int PADDING      = 0,
    parameter int DATA_WIDTH   = 8,
    parameter int CHANNELS     = 1,
    localparam int HORIZONTAL_POSITIONS = positions(IMAGE_WIDTH, KERNEL_SIZE, STRIDE, PADDING),
    localparam int VERTICAL_POSITIONS   = positions(IMAGE_HEIGHT, KERNEL_SIZE, STRIDE, PADDING)
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              in_valid,
    output logic                                              in_ready,
    input  logic [CHANNELS*DATA_WIDTH-1:0]                    in_pixel,
    output logic                                              out_valid,
    input  logic                                              out_ready,
    output logic [KERNEL_SIZE*KERNEL_SIZE*CHANNELS*DATA_WIDTH-1:0] out_column,
    output logic                                              out_last
);

    localparam int PIXEL_W = CHANNELS * DATA_WIDTH;
    localparam int ROW_W   = count_width(IMAGE_HEIGHT);
    localparam int COL_W   = count_width(IMAGE_WIDTH);
    localparam int PY_W    = count_width(VERTICAL_POSITIONS);
    localparam int PX_W    = count_width(HORIZONTAL_POSITIONS);

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMAGE_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMAGE_WIDTH - 1);
    localparam logic [PY_W-1:0]  PY_LAST  = PY_W'(VERTICAL_POSITIONS - 1);
    localparam logic [PX_W-1:0]  PX_LAST  = PX_W'(HORIZONTAL_POSITIONS - 1);

    if (!params_legal(IMAGE_WIDTH, IMAGE_HEIGHT, KERNEL_SIZE, STRIDE, PADDING)) begin : g_param_check
        $error("im2col_stream: kernel larger than padded image or STRIDE < 1");
    end

    state_t                                         state;
    logic [ROW_W-1:0]                               row;
    logic [COL_W-1:0]                               col;
    logic [PY_W-1:0]                                py;
    logic [PX_W-1:0]                                px;
    logic [IMAGE_HEIGHT*IMAGE_WIDTH*PIXEL_W-1:0]    frame;
    logic                                           in_fire;
    logic                                           out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // Controller: raster write counters during LOAD, window position counters
    // during EMIT. in_ready/out_valid are registered alongside the state so
    // they change exactly one cycle after the last input / last output handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= LOAD;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            row       <= '0;
            col       <= '0;
            py        <= '0;
            px        <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (in_fire) begin
                        if (col == COL_LAST) begin
                            col <= '0;
                            if (row == ROW_LAST) begin
                                row       <= '0;
                                state     <= EMIT;
                                in_ready  <= 1'b0;
                                out_valid <= 1'b1;
                            end else begin
                                row <= row + 1'b1;
                            end
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (out_fire) begin
                        if (px == PX_LAST) begin
                            px <= '0;
                            if (py == PY_LAST) begin
                                py        <= '0;
                                state     <= LOAD;
                                in_ready  <= 1'b1;
                                out_valid <= 1'b0;
                            end else begin
                                py <= py + 1'b1;
                            end
                        end else begin
                            px <= px + 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= LOAD;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Frame storage has no reset: every location is rewritten before the next
    // EMIT phase reads it, so stale data from an aborted frame is harmless.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            frame[(int'(row)*IMAGE_WIDTH + int'(col))*PIXEL_W +: PIXEL_W] <= in_pixel;
        end
    end

    assign out_last = out_valid && (py == PY_LAST) && (px == PX_LAST);

    im2col_window_mux #(
        .IMAGE_WIDTH  (IMAGE_WIDTH),
        .IMAGE_HEIGHT (IMAGE_HEIGHT),
        .KERNEL_SIZE  (KERNEL_SIZE),
        .STRIDE       (STRIDE),
        .PADDING      (PADDING),
        .DATA_WIDTH   (DATA_WIDTH),
        .CHANNELS     (CHANNELS)
    ) u_window_mux (
        .frame      (frame),
        .py         (py),
        .px         (px),
        .out_column (out_column)
    );

endmodule

// File: tb/tb_im2col_stream.sv
// ---------------------------------------------------------------------------
// tb_im2col_stream
// Directed bench for im2col_stream. Four instances cover the configurations
// of interest:
//   dut_a : 4x4, K=3, S=1, P=0, C=1
//   dut_b : 4x4, K=3, S=1, P=1, C=1
//   dut_c : 5x5, K=3, S=2, P=0, C=1
//   dut_d : 4x4, K=3, S=1, P=0, C=2 (channel1 = 100 + channel0)
// Inputs are driven on the falling edge and outputs sampled there too.
// ---------------------------------------------------------------------------
module tb_im2col_stream;

    logic         clk;
    logic         rst;
    logic [3:0]   in_valid;
    logic [3:0]   in_ready;
    logic [3:0]   out_valid;
    logic [3:0]   out_ready;
    logic [3:0]   out_last;
    logic [7:0]   pix_a, pix_b, pix_c;
    logic [15:0]  pix_d;
    logic [71:0]  col_a, col_b, col_c;
    logic [143:0] col_d;

    int           checks;
    int           errors;
    logic [143:0] cols[$];
    bit           lasts[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    im2col_stream #(.IMAGE_WIDTH(4), .IMAGE_HEIGHT(4), .KERNEL_SIZE(3), .STRIDE(1),
                    .PADDING(0), .DATA_WIDTH(8), .CHANNELS(1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_pixel(pix_a), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_column(col_a), .out_last(out_last[0]));

    im2col_stream #(.IMAGE_WIDTH(4), .IMAGE_HEIGHT(4), .KERNEL_SIZE(3), .STRIDE(1),
                    .PADDING(1), .DATA_WIDTH(8), .CHANNELS(1)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_pixel(pix_b), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_column(col_b), .out_last(out_last[1]));

    im2col_stream #(.IMAGE_WIDTH(5), .IMAGE_HEIGHT(5), .KERNEL_SIZE(3), .STRIDE(2),
                    .PADDING(0), .DATA_WIDTH(8), .CHANNELS(1)) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_pixel(pix_c), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_column(col_c), .out_last(out_last[2]));

    im2col_stream #(.IMAGE_WIDTH(4), .IMAGE_HEIGHT(4), .KERNEL_SIZE(3), .STRIDE(1),
                    .PADDING(0), .DATA_WIDTH(8), .CHANNELS(2)) dut_d (
        .clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
        .in_pixel(pix_d), .out_valid(out_valid[3]), .out_ready(out_ready[3]),
        .out_column(col_d), .out_last(out_last[3]));

    // Builds an expected column from nine hand-listed channel-0 pixel values;
    // for two-channel columns channel 1 is the same pixel plus 100.
    function automatic logic [143:0] pack9(input bit two_ch, input int p0, input int p1,
                                           input int p2, input int p3, input int p4,
                                           input int p5, input int p6, input int p7,
                                           input int p8);
        int           p[9];
        logic [143:0] r;
        p = '{p0, p1, p2, p3, p4, p5, p6, p7, p8};
        r = '0;
        for (int i = 0; i < 9; i++) begin
            if (two_ch) begin
                r[(2*i)*8 +: 8]   = 8'(p[i]);
                r[(2*i+1)*8 +: 8] = 8'(p[i] + 100);
            end else begin
                r[i*8 +: 8] = 8'(p[i]);
            end
        end
        return r;
    endfunction

    function automatic logic [143:0] cur_col(input int idx);
        case (idx)
            0:       return {72'd0, col_a};
            1:       return {72'd0, col_b};
            2:       return {72'd0, col_c};
            default: return col_d;
        endcase
    endfunction

    function automatic logic [143:0] col_at(input int i);
        return (i < cols.size()) ? cols[i] : '1;
    endfunction

    function automatic bit last_at(input int i);
        return (i < lasts.size()) ? lasts[i] : 1'b0;
    endfunction

    task automatic check(input string tag, input logic [143:0] observed,
                         input logic [143:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic set_pixel(input int idx, input int v);
        case (idx)
            0:       pix_a = 8'(v);
            1:       pix_b = 8'(v);
            2:       pix_c = 8'(v);
            default: pix_d = {8'(v + 100), 8'(v)};
        endcase
    endtask

    // Streams pixels off+1 .. off+npix in raster order. With hold set the
    // source keeps in_valid high (with a junk pixel) once the frame is in.
    task automatic load_frame(input int idx, input int npix, input int off, input bit hold);
        int w;
        for (int n = 1; n <= npix; n++) begin
            @(negedge clk);
            in_valid[idx] = 1'b1;
            set_pixel(idx, n + off);
            w = 0;
            while (!in_ready[idx] && w < 20) begin
                @(negedge clk);
                w++;
            end
            if (w >= 20) begin
                check("load_ready_timeout", {143'd0, in_ready[idx]}, 144'd1);
                in_valid[idx] = 1'b0;
                return;
            end
        end
        @(negedge clk);
        if (hold) set_pixel(idx, 200);
        else      in_valid[idx] = 1'b0;
        check("valid_after_load", {143'd0, out_valid[idx]}, 144'd1);
        check("ready_after_load", {143'd0, in_ready[idx]}, 144'd0);
    endtask

    // Presents out_ready and samples the column that the next rising edge consumes.
    task automatic get_col(input int idx, output logic [143:0] c, output bit l,
                           output int waited, output bit ok);
        @(negedge clk);
        out_ready[idx] = 1'b1;
        waited = 0;
        while (!out_valid[idx] && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        ok = out_valid[idx];
        if (!ok) check("column_valid_timeout", {143'd0, out_valid[idx]}, 144'd1);
        c = cur_col(idx);
        l = out_last[idx];
    endtask

    task automatic collect_frame(input int idx, input int expect_n);
        logic [143:0] c;
        bit           l;
        bit           ok;
        bit           done;
        int           waited;
        int           n;
        cols.delete();
        lasts.delete();
        n    = 0;
        done = 1'b0;
        while (!done && n < expect_n + 2) begin
            get_col(idx, c, l, waited, ok);
            if (!ok) break;
            if (n > 0) check("back_to_back", 144'(waited), 144'd0);
            check("ready_low_in_emit", {143'd0, in_ready[idx]}, 144'd0);
            cols.push_back(c);
            lasts.push_back(l);
            n++;
            done = l;
        end
        @(negedge clk);
        out_ready[idx] = 1'b0;
        check("column_count", 144'(n), 144'(expect_n));
        check("ready_after_frame", {143'd0, in_ready[idx]}, 144'd1);
        check("valid_after_frame", {143'd0, out_valid[idx]}, 144'd0);
    endtask

    initial begin
        logic [143:0] c;
        logic [143:0] held;
        bit           l;
        bit           ok;
        int           waited;

        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = '0;
        out_ready = '0;
        pix_a     = '0;
        pix_b     = '0;
        pix_c     = '0;
        pix_d     = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        $display("[TB] reset state");
        for (int i = 0; i < 4; i++) begin
            check("reset_in_ready", {143'd0, in_ready[i]}, 144'd1);
            check("reset_out_valid", {143'd0, out_valid[i]}, 144'd0);
            check("reset_out_last", {143'd0, out_last[i]}, 144'd0);
        end

        $display("[TB] 4x4 K3 S1 P0");
        load_frame(0, 16, 0, 1'b0);
        collect_frame(0, 4);
        check("a_col0", col_at(0), pack9(0, 1, 2, 3, 5, 6, 7, 9, 10, 11));
        check("a_col1", col_at(1), pack9(0, 2, 3, 4, 6, 7, 8, 10, 11, 12));
        check("a_col2", col_at(2), pack9(0, 5, 6, 7, 9, 10, 11, 13, 14, 15));
        check("a_col3", col_at(3), pack9(0, 6, 7, 8, 10, 11, 12, 14, 15, 16));
        check("a_last0", {143'd0, last_at(0)}, 144'd0);
        check("a_last3", {143'd0, last_at(3)}, 144'd1);

        $display("[TB] 4x4 K3 S1 P1");
        load_frame(1, 16, 0, 1'b0);
        collect_frame(1, 16);
        check("b_col0", col_at(0), pack9(0, 0, 0, 0, 0, 1, 2, 0, 5, 6));
        check("b_col3", col_at(3), pack9(0, 0, 0, 0, 3, 4, 0, 7, 8, 0));
        check("b_col5", col_at(5), pack9(0, 1, 2, 3, 5, 6, 7, 9, 10, 11));
        check("b_col15", col_at(15), pack9(0, 11, 12, 0, 15, 16, 0, 0, 0, 0));
        check("b_last14", {143'd0, last_at(14)}, 144'd0);
        check("b_last15", {143'd0, last_at(15)}, 144'd1);

        $display("[TB] 5x5 K3 S2 P0");
        load_frame(2, 25, 0, 1'b0);
        collect_frame(2, 4);
        check("c_col0", col_at(0), pack9(0, 1, 2, 3, 6, 7, 8, 11, 12, 13));
        check("c_col1", col_at(1), pack9(0, 3, 4, 5, 8, 9, 10, 13, 14, 15));
        check("c_col2", col_at(2), pack9(0, 11, 12, 13, 16, 17, 18, 21, 22, 23));
        check("c_col3", col_at(3), pack9(0, 13, 14, 15, 18, 19, 20, 23, 24, 25));
        check("c_last3", {143'd0, last_at(3)}, 144'd1);

        $display("[TB] two channels");
        load_frame(3, 16, 0, 1'b0);
        collect_frame(3, 4);
        check("d_col0", col_at(0), pack9(1, 1, 2, 3, 5, 6, 7, 9, 10, 11));
        check("d_col3", col_at(3), pack9(1, 6, 7, 8, 10, 11, 12, 14, 15, 16));

        $display("[TB] backpressure with in_valid held high");
        load_frame(0, 16, 0, 1'b1);
        get_col(0, c, l, waited, ok);
        check("bp_col0", c, pack9(0, 1, 2, 3, 5, 6, 7, 9, 10, 11));
        @(negedge clk);
        out_ready[0] = 1'b0;
        held = cur_col(0);
        check("bp_held_col1", held, pack9(0, 2, 3, 4, 6, 7, 8, 10, 11, 12));
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            check("bp_stable_col", cur_col(0), held);
            check("bp_stable_last", {143'd0, out_last[0]}, 144'd0);
            check("bp_valid", {143'd0, out_valid[0]}, 144'd1);
            check("bp_in_ready", {143'd0, in_ready[0]}, 144'd0);
        end
        get_col(0, c, l, waited, ok);
        check("bp_col1", c, pack9(0, 2, 3, 4, 6, 7, 8, 10, 11, 12));
        get_col(0, c, l, waited, ok);
        check("bp_col2", c, pack9(0, 5, 6, 7, 9, 10, 11, 13, 14, 15));
        get_col(0, c, l, waited, ok);
        in_valid[0] = 1'b0;
        check("bp_col3", c, pack9(0, 6, 7, 8, 10, 11, 12, 14, 15, 16));
        check("bp_last3", {143'd0, l}, 144'd1);
        @(negedge clk);
        out_ready[0] = 1'b0;
        check("bp_ready_after", {143'd0, in_ready[0]}, 144'd1);
        check("bp_valid_after", {143'd0, out_valid[0]}, 144'd0);

        $display("[TB] reset in the middle of EMIT");
        load_frame(0, 16, 0, 1'b0);
        get_col(0, c, l, waited, ok);
        get_col(0, c, l, waited, ok);
        @(negedge clk);
        check("rst_pre_col2", cur_col(0), pack9(0, 5, 6, 7, 9, 10, 11, 13, 14, 15));
        out_ready[0] = 1'b0;
        rst          = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", {143'd0, in_ready[0]}, 144'd1);
        check("rst_out_valid", {143'd0, out_valid[0]}, 144'd0);
        check("rst_out_last", {143'd0, out_last[0]}, 144'd0);
        load_frame(0, 16, 50, 1'b0);
        collect_frame(0, 4);
        check("rst_col0", col_at(0), pack9(0, 51, 52, 53, 55, 56, 57, 59, 60, 61));
        check("rst_col1", col_at(1), pack9(0, 52, 53, 54, 56, 57, 58, 60, 61, 62));
        check("rst_col3", col_at(3), pack9(0, 56, 57, 58, 60, 61, 62, 64, 65, 66));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Backstop so a wedged handshake can never hang the run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
